spm_seq: RTL and testbench
==========================

# spm_seq

Operand sequencer and product collector wrapped around the serial-parallel multiplier (spm) carry-save array. It accepts a parallel operand pair over a valid/ready handshake and holds multiplier `a` on the array's parallel `x` inputs. It shifts multiplicand `b` LSB-first into the array's serial `y` input and deserialises the array's serial product bit into a 2·WIDTH-bit result, offered on a valid/ready output. It sits directly upstream of and around the `genblk1[*].csa` cell chain, owning its clearing and bit framing.

## Interface
Parameters:
- `WIDTH`, 32: operand width; equals the number of CSA cells in the array.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept; high only in IDLE.
- `a`  in  WIDTH  multiplier (parallel operand).
- `b`  in  WIDTH  multiplicand (serialised operand).
- `spm_x`  out  WIDTH  to array `x`; registered copy of `a`.
- `spm_y`  out  1  to array serial `y`; registered.
- `spm_clr`  out  1  to array `rst`; clears all CSA sum/carry flops.
- `spm_p`  in  1  array serial product bit; bit k valid one cycle after `y` bit k is driven.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `product`  out  2·WIDTH  result, a·b mod 2^(2·WIDTH).

## Operation
- FSM states: IDLE, CLEAR, SHIFT, CAPT, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `a` into `spm_x` and `b` into the operand shift register. Clear `product` and the counter, then go to CLEAR.
- CLEAR, 1 cycle: `spm_clr`=1, `spm_y`=0. Go to SHIFT.
- SHIFT, 2·WIDTH cycles, counter `cnt` = 0..2·WIDTH−1:
  - `cnt` < WIDTH: `spm_y` = b[cnt].
  - `cnt` ≥ WIDTH: `spm_y` = extension bit (see Configuration).
  - `cnt` ≥ 1: shift `spm_p` into the MSB of `product` (right shift); this captures product bit cnt−1.
  - At `cnt` = 2·WIDTH−1, go to CAPT.
- CAPT, 1 cycle: `spm_y`=0. Shift the final `spm_p` (bit 2·WIDTH−1) into `product`. Go to DONE.
- DONE: `out_valid`=1; `product` and `spm_x` are stable. On `out_ready`, go to IDLE.
- `spm_clr` = `rst` | (state==CLEAR). The array is therefore also cleared throughout reset.
- `in_valid` is ignored outside IDLE. `in_ready` is never asserted in the same cycle as `out_valid`.
- Counter width is $clog2(2·WIDTH). It never wraps; the SHIFT exit compares against 2·WIDTH−1.

## Timing
- Reset values: state IDLE, `spm_x`=0, `spm_y`=0, `product`=0, `out_valid`=0, counter 0. `in_ready` reads 1 in the first cycle after `rst` deasserts.
- Accept edge t → `spm_clr` high in cycle t+1 → `spm_y` bit 0 in cycle t+2 → `out_valid` high in cycle t+2·WIDTH+3. Latency is 2·WIDTH+3 cycles (67 for WIDTH=32).
- Output handshake at edge u: `in_ready`=1 in cycle u+1. Minimum initiation interval is 2·WIDTH+4 cycles.
- `rst` in any state takes effect at the next edge: IDLE, `product` cleared, no `out_valid` pulse. A partial product is never presented.
- `out_ready` held low: DONE persists indefinitely with all outputs frozen.

## Configuration
- `SPM_SEQ_SIGNED_EN` defined:
  - SHIFT cycles with `cnt` ≥ WIDTH drive `spm_y` = b[WIDTH−1] (sign extension).
  - The product is the two's-complement a·b. The array must be the signed-x variant.
- `SPM_SEQ_SIGNED_EN` not defined:
  - Those cycles drive `spm_y` = 0.
  - The product is the unsigned a·b.

## Structure
- Package `spm_pkg`: FSM state enum typedef `spm_seq_state_t`, localparam `SPM_WIDTH` = 32, and the counter-width function.
- One sub-module, `spm_seq_sipo`: serial-in/parallel-out product register with shift-enable and synchronous clear.
- The FSM, counter and operand shift register stay in `spm_seq`.

## Test plan
The bench drives `spm_p` from the spm array, or from a one-cycle-latency behavioural model.

- a=3, b=5, `out_ready`=1 → `product`=15, `out_valid` exactly 67 cycles after accept, single-cycle DONE.
- a=b=0xFFFFFFFF, unsigned → `product`=0xFFFFFFFE00000001.
- a=0xFFFFFFFD, b=5:
  - without macro → `product`=0x00000004FFFFFFF1.
  - with `SPM_SEQ_SIGNED_EN` → `product`=0xFFFFFFFFFFFFFFF1.
- `out_ready` low for 10 cycles in DONE, `in_valid` high throughout → `product`, `out_valid`=1 and `in_ready`=0 all stable; second accept one cycle after the handshake.
- `rst` pulsed for one cycle at `cnt`=20 → next cycle IDLE, `product`=0, `spm_clr` was high during reset, no `out_valid`. A subsequent a=7, b=6 yields 42.
- Back-to-back, `in_valid` held high, pairs (2,9) then (11,13) → products 18 then 143, accepts spaced exactly 2·WIDTH+4 cycles.

Source files
------------

// File: rtl/spm_seq_pkg.sv
// Shared types and constants for the spm operand sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: spm_seq_state_t FSM encoding, SPM_WIDTH default operand width,
//           spm_cnt_width() sizing helper for the bit counter.
package spm_pkg;

  localparam int SPM_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } spm_seq_state_t;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int spm_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spm_seq_if.sv
// Operand-in / product-out handshake bundle for spm_seq.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the product side.
// Ports: in_valid/in_ready/a/b (operand pair), out_valid/out_ready/product.
//        master = producer/consumer side, slave = sequencer side.
interface spm_seq_if
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/spm_seq_sipo.sv
// Serial-in / parallel-out product register; bits enter at the MSB and shift right.
// Latency: one cycle from shift_en to the bit landing in q.
// Backpressure: none; shifts whenever shift_en is high, clr has priority.
// Ports: clk, rst (sync, active-high), clr (sync clear), shift_en, din, q.
module spm_seq_sipo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (shift_en) begin
      // LSB-first arrival: after W shifts the first bit sits at q[0].
      q_d = {din, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spm_seq.sv
// Operand sequencer and product collector around the serial-parallel multiplier array.
// Latency: 2*WIDTH+3 cycles from operand accept to out_valid; initiation interval 2*WIDTH+4.
// Backpressure: in_ready only in IDLE; DONE holds product/spm_x frozen until out_ready.
// Ports: clk, rst (sync, active-high); bus (spm_seq_if.slave: operand and product handshakes);
//        spm_x/spm_y/spm_clr to the array, spm_p serial product bit back from it.
// Build option: SPM_SEQ_SIGNED_EN sign-extends b into the upper half of the
//        serial stream (two's-complement product, needs the signed-x array);
//        undefined, the upper half is zero-filled (unsigned product).
module spm_seq
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  spm_seq_if.slave         bus,
  output logic [WIDTH-1:0] spm_x,
  output logic             spm_y,
  output logic             spm_clr,
  input  logic             spm_p
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = spm_cnt_width(PW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW - 1);

  spm_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] bsh_q, bsh_d;
  logic             y_q, y_d;
  logic             prod_clr;
  logic             prod_shift;
  logic             ext_fill;

  // Fill bit entering the top of the operand shifter. After WIDTH shifts the
  // LSB presents only this bit, which supplies the extension half of the stream.
`ifdef SPM_SEQ_SIGNED_EN
  assign ext_fill = bsh_q[WIDTH-1];
`else
  assign ext_fill = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    bsh_d      = bsh_q;
    y_d        = 1'b0;
    prod_clr   = 1'b0;
    prod_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d  = ST_CLEAR;
          x_d      = bus.a;
          bsh_d    = bus.b;
          cnt_d    = '0;
          prod_clr = 1'b1;
        end
      end
      ST_CLEAR: begin
        // y is registered, so bit 0 is loaded here to appear in SHIFT cnt=0.
        y_d     = bsh_q[0];
        bsh_d   = {ext_fill, bsh_q[WIDTH-1:1]};
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Array output lags y by one cycle: cnt=0 has no product bit yet.
        prod_shift = (cnt_q != '0);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPT;
        end else begin
          y_d   = bsh_q[0];
          bsh_d = {ext_fill, bsh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPT: begin
        prod_shift = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      bsh_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      bsh_q   <= bsh_d;
      y_q     <= y_d;
    end
  end

  spm_seq_sipo #(
    .W (PW)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (prod_clr),
    .shift_en (prod_shift),
    .din      (spm_p),
    .q        (bus.product)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign spm_x         = x_q;
  assign spm_y         = y_q;
  // Array is held clear for the whole of reset as well as the CLEAR cycle.
  assign spm_clr       = rst | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_spm_seq.sv
// Self-checking bench for spm_seq with a one-cycle-latency behavioural model of the spm array.
// Latency: checks accept-to-valid latency and initiation interval.
// Backpressure: exercises out_ready stall in DONE and in_valid held high.
module tb_spm_seq;
  import spm_pkg::*;

  localparam int W = SPM_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] spm_x;
  logic         spm_y;
  logic         spm_clr;
  logic         spm_p;

  spm_seq_if #(.WIDTH(W)) bus ();

  spm_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .spm_x   (spm_x),
    .spm_y   (spm_y),
    .spm_clr (spm_clr),
    .spm_p   (spm_p)
  );

  always #5 clk = ~clk;

  // ---------------- array model: p(k) = bit k of sum_{j<=k} y_j*x*2^j ----
  logic [127:0] acc;
  int           k;
  logic         p_q;

  always @(posedge clk) begin
    logic [127:0] xext;
    logic [127:0] nx;
`ifdef SPM_SEQ_SIGNED_EN
    xext = {{(128-W){spm_x[W-1]}}, spm_x};
`else
    xext = {{(128-W){1'b0}}, spm_x};
`endif
    if (spm_clr) begin
      acc <= '0;
      k   <= 0;
      p_q <= 1'b0;
    end else begin
      nx  = acc + (spm_y ? (xext << k) : 128'd0);
      acc <= nx;
      p_q <= nx[k];
      if (k < 127) k <= k + 1;
    end
  end

  assign spm_p = p_q;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  int          hs_edge  = 0;
  int          vld_cycle = 0;
  logic        vld_prev = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_prod(input logic [31:0] x, input logic [31:0] y);
`ifdef SPM_SEQ_SIGNED_EN
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
`else
    return {32'd0, x} * {32'd0, y};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask

  // Output monitor: samples 2 time units after the falling edge so it sees
  // inputs the main thread drives at that edge.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      vld_prev = 1'b0;
    end else begin
      if (bus.out_valid && !vld_prev) vld_cycle = cyc + 1;
      vld_prev = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        hs_edge = cyc + 1;
        n_out++;
        if (exp_q.size() == 0) check("sb_unexpected", 64'(exp_q.size()), 64'd1);
        else check("product", bus.product, exp_q.pop_front());
      end
    end
  end

  // Drive an operand pair from a falling edge; acc returns the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit hold, output int acc);
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    acc          = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.in_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      exp_q.push_back(exp_prod(x, y));
    end
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 400 && n_out < target; i++) begin
      @(negedge clk);
      #3;
    end
    if (n_out < target) check("out_timeout", 64'(n_out), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int a1, a2, nb;
    logic [63:0] stall_exp;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_in_reset", 64'(spm_clr), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_product",   bus.product,        64'd0);
    check("rst_spm_x",     64'(spm_x),         64'd0);
    check("rst_spm_y",     64'(spm_y),         64'd0);
    check("rst_spm_clr",   64'(spm_clr),       64'd0);

    // 3*5, latency and single-cycle DONE
    send(32'd3, 32'd5, 1'b0, a1);
    wait_out(1);
    check("latency", 64'(vld_cycle - a1), 64'd67);
    @(negedge clk);
    check("done_1cyc", 64'(bus.out_valid), 64'd0);

    // all-ones operands, then negative-looking a
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, a1);
    wait_out(2);
    send(32'hFFFF_FFFD, 32'd5, 1'b0, a1);
    wait_out(3);

    // stall in DONE with in_valid held high
    @(negedge clk);
    bus.out_ready = 1'b0;
    stall_exp = exp_prod(32'h1234_5678, 32'h0000_9ABC);
    send(32'h1234_5678, 32'h0000_9ABC, 1'b1, a1);
    for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
    check("stall_reach_done", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("stall_product",   bus.product,        stall_exp);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(32'h0000_CAFE, 32'h0000_0BAD, 1'b0, a2);
    check("accept_after_hs", 64'(a2 - hs_edge), 64'd1);
    wait_out(5);

    // reset mid-multiply
    @(negedge clk);
    send(32'h0000_1111, 32'h0000_2222, 1'b0, a1);
    repeat (21) @(negedge clk);
    check("cnt_at_rst", 64'(dut.cnt_q), 64'd20);
    rst = 1'b1;
    #1;
    check("clr_during_rst", 64'(spm_clr), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("post_rst_product",   bus.product,        64'd0);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    nb = n_out;
    repeat (80) @(negedge clk);
    check("no_partial_out", 64'(n_out), 64'(nb));
    send(32'd7, 32'd6, 1'b0, a1);
    wait_out(nb + 1);

    // back-to-back with in_valid held high
    @(negedge clk);
    send(32'd2, 32'd9, 1'b1, a1);
    send(32'd11, 32'd13, 1'b0, a2);
    wait_out(nb + 3);
    check("b2b_spacing", 64'(a2 - a1), 64'd68);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
